// File: rtl/rpd_pkg.sv
// Shared types and helpers for the R-peak detection datapath.
package rpd_pkg;

    // Default ECG sample width: signed, two's complement, -1024..1023.
    localparam int DEFAULT_DATA_WIDTH = 11;

    typedef logic signed [DEFAULT_DATA_WIDTH-1:0] sample_t;

    // A running sum of 2^window_log2 samples needs window_log2 extra bits.
    // Because |sum| <= 2^window_log2 * 2^(data_width-1), it never overflows.
    function automatic int sum_width(input int window_log2,
                                     input int data_width = DEFAULT_DATA_WIDTH);
        return data_width + window_log2;
    endfunction

endpackage

// File: rtl/sample_ring.sv
// Circular sample store with one synchronous write port and an asynchronous
// read port. It has no reset, so it can map onto distributed RAM.
module sample_ring
    import rpd_pkg::*;
#(
    parameter int DEPTH_LOG2 = 5,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // Store the new sample in the slot chosen by the caller.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The read is combinational, so a read and a write to the same slot in one
    // cycle return the old contents.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/moving_avg.sv
// Boxcar moving average over the last 2^WINDOW_LOG2 accepted ECG samples.
// It keeps a running sum and a circular buffer. Division is an arithmetic
// shift that rounds toward minus infinity.
//
// Handshake: i_ce is a one-way strobe with no back-pressure. Every cycle with
// i_ce=1 consumes i_ecg_sample. o_ce is high for exactly one cycle per consumed
// sample, one cycle later, and o_ecg_sample/o_ma are valid in that cycle. The
// consumer must take them then.
module moving_avg
    import rpd_pkg::*;
#(
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int WINDOW_LOG2 = 5
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_ce,
    input  logic signed [DATA_WIDTH-1:0] i_ecg_sample,
    output logic                         o_ce,
    output logic signed [DATA_WIDTH-1:0] o_ecg_sample,
    output logic signed [DATA_WIDTH-1:0] o_ma,
    output logic                         o_ma_valid
);

    localparam int SUM_WIDTH = sum_width(WINDOW_LOG2, DATA_WIDTH);
    // The window length W, held in a fill-counter-wide constant.
    localparam logic [WINDOW_LOG2:0] FILL_MAX = {1'b1, {WINDOW_LOG2{1'b0}}};

    logic [WINDOW_LOG2-1:0]       wr_ptr;
    logic [WINDOW_LOG2:0]         fill_cnt;
    logic signed [SUM_WIDTH-1:0]  sum;
    logic signed [SUM_WIDTH-1:0]  sum_next;
    logic signed [SUM_WIDTH-1:0]  x_ext;
    logic signed [SUM_WIDTH-1:0]  old_ext;
    logic signed [DATA_WIDTH-1:0] rd_data;
    logic signed [DATA_WIDTH-1:0] old_sample;
    logic                         full;

    sample_ring #(
        .DEPTH_LOG2 (WINDOW_LOG2),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ring (
        .i_clk   (i_clk),
        .wr_en   (i_ce && !i_rst),
        .wr_addr (wr_ptr),
        .wr_data (i_ecg_sample),
        .rd_addr (wr_ptr),
        .rd_data (rd_data)
    );

    // Leaving sample and new sample, sign-extended, and the updated running sum.
    always_comb begin
        full       = (fill_cnt == FILL_MAX);
        old_sample = full ? rd_data : '0;
        x_ext      = {{WINDOW_LOG2{i_ecg_sample[DATA_WIDTH-1]}}, i_ecg_sample};
        old_ext    = {{WINDOW_LOG2{old_sample[DATA_WIDTH-1]}}, old_sample};
        sum_next   = sum + x_ext - old_ext;
    end

    // Pointer, fill count, running sum and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr       <= '0;
            fill_cnt     <= '0;
            sum          <= '0;
            o_ce         <= 1'b0;
            o_ecg_sample <= '0;
            o_ma         <= '0;
            o_ma_valid   <= 1'b0;
        end else if (i_ce) begin
            wr_ptr       <= wr_ptr + 1'b1;
            if (!full) begin
                fill_cnt <= fill_cnt + 1'b1;
            end
            sum          <= sum_next;
            o_ce         <= 1'b1;
            o_ecg_sample <= i_ecg_sample;
            // sum_next >>> WINDOW_LOG2, truncated to DATA_WIDTH, is exactly the
            // top DATA_WIDTH bits of the sum.
            o_ma         <= sum_next[SUM_WIDTH-1:WINDOW_LOG2];
            if ((fill_cnt + 1'b1) >= FILL_MAX) begin
                o_ma_valid <= 1'b1;
            end
        end else begin
            o_ce         <= 1'b0;
        end
    end

endmodule

// File: tb/tb_moving_avg.sv
// Directed bench for moving_avg with a window of 4 samples.
module tb_moving_avg;
    import rpd_pkg::*;

    localparam int DW = DEFAULT_DATA_WIDTH;

    logic          i_clk;
    logic          i_rst;
    logic          i_ce;
    sample_t       i_ecg_sample;
    logic          o_ce;
    sample_t       o_ecg_sample;
    sample_t       o_ma;
    logic          o_ma_valid;

    int vectors    = 0;
    int miscompares = 0;
    int ce_pulses;
    logic [DW-1:0] exp_q[$];

    moving_avg #(
        .DATA_WIDTH  (DW),
        .WINDOW_LOG2 (2)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_ce         (i_ce),
        .i_ecg_sample (i_ecg_sample),
        .o_ce         (o_ce),
        .o_ecg_sample (o_ecg_sample),
        .o_ma         (o_ma),
        .o_ma_valid   (o_ma_valid)
    );

    // Clock and reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Driver tasks
    task automatic step(input logic ce, input int x);
        @(negedge i_clk);
        i_rst        = 1'b0;
        i_ce         = ce;
        i_ecg_sample = DW'(x);
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset(input logic ce_during);
        @(negedge i_clk);
        i_rst        = 1'b1;
        i_ce         = ce_during;
        i_ecg_sample = 11'sd500;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ce, input int ecg,
                             input int ma, input logic valid);
        check({tag, ".o_ce"}, {31'd0, o_ce}, {31'd0, ce});
        check({tag, ".o_ecg_sample"}, o_ecg_sample, ecg);
        check({tag, ".o_ma"}, o_ma, ma);
        check({tag, ".o_ma_valid"}, {31'd0, o_ma_valid}, {31'd0, valid});
    endtask

    // Stimulus, checks and report
    initial begin
        logic [DW-1:0] e;
        int pat [7];
        int ma_exp [7];
        i_rst        = 1'b1;
        i_ce         = 1'b0;
        i_ecg_sample = '0;
        repeat (2) @(posedge i_clk);
        #1;
        check_all("reset", 1'b0, 0, 0, 1'b0);

        // Constant 100, back to back: partial sums 25, 50, 75 then 100.
        step(1'b1, 100); check_all("c100_1", 1'b1, 100, 25, 1'b0);
        step(1'b1, 100); check_all("c100_2", 1'b1, 100, 50, 1'b0);
        step(1'b1, 100); check_all("c100_3", 1'b1, 100, 75, 1'b0);
        step(1'b1, 100); check_all("c100_4", 1'b1, 100, 100, 1'b1);
        step(1'b1, 100); check_all("c100_5", 1'b1, 100, 100, 1'b1);
        step(1'b1, 100); check_all("c100_6", 1'b1, 100, 100, 1'b1);

        // Reset wins over a simultaneous strobe.
        do_reset(1'b1);
        check_all("rst_ce", 1'b0, 0, 0, 1'b0);

        // 4, 8, 12, 16, 20: sums 4, 12, 24, 40, then 40+20-4 = 56.
        exp_q = '{11'd1, 11'd3, 11'd6, 11'd10, 11'd14};
        for (int k = 1; k <= 5; k++) begin
            step(1'b1, 4 * k);
            e = exp_q.pop_front();
            check($sformatf("ramp_%0d.o_ma", k), o_ma, $signed(e));
            check($sformatf("ramp_%0d.o_ecg", k), o_ecg_sample, 4 * k);
            check($sformatf("ramp_%0d.valid", k), {31'd0, o_ma_valid},
                  (k >= 4) ? 1 : 0);
        end

        // -1, 0, 0, 0: sum stays -1, which floors to -1; then zeros flush it.
        do_reset(1'b0);
        step(1'b1, -1); check_all("neg_1", 1'b1, -1, -1, 1'b0);
        step(1'b1, 0);
        step(1'b1, 0);
        step(1'b1, 0);  check_all("neg_4", 1'b1, 0, -1, 1'b1);
        step(1'b1, 0);  check_all("zero_1", 1'b1, 0, 0, 1'b1);
        step(1'b1, 0);
        step(1'b1, 0);
        step(1'b1, 0);  check_all("zero_4", 1'b1, 0, 0, 1'b1);

        // Extremes.
        do_reset(1'b0);
        repeat (4) step(1'b1, -1024);
        check_all("min4", 1'b1, -1024, -1024, 1'b1);
        step(1'b1, 1023);
        check("min_max_1.o_ma", o_ma, -513);
        repeat (3) step(1'b1, 1023);
        check_all("max4", 1'b1, 1023, 1023, 1'b1);
        step(1'b1, -1024);
        step(1'b1, 1023);
        step(1'b1, -1024);
        step(1'b1, 1023);
        check_all("alt4", 1'b1, 1023, -1, 1'b1);

        // Gapped strobes; idle cycles carry a junk sample that must be ignored.
        do_reset(1'b0);
        pat    = '{1, 0, 0, 1, 0, 1, 1};
        ma_exp = '{2, 2, 2, 4, 4, 6, 8};
        ce_pulses = 0;
        for (int k = 0; k < 7; k++) begin
            step(pat[k][0], (pat[k] != 0) ? 8 : 77);
            if (o_ce) ce_pulses++;
            check($sformatf("gap_%0d.o_ce", k), {31'd0, o_ce}, pat[k]);
            check($sformatf("gap_%0d.o_ecg", k), o_ecg_sample, 8);
            check($sformatf("gap_%0d.o_ma", k), o_ma, ma_exp[k]);
            check($sformatf("gap_%0d.valid", k), {31'd0, o_ma_valid},
                  (k == 6) ? 1 : 0);
        end
        step(1'b0, 55);
        if (o_ce) ce_pulses++;
        check_all("gap_hold", 1'b0, 8, 8, 1'b1);
        check("gap_pulses", ce_pulses, 4);

        // Reset mid-fill: no leakage of the earlier 1000s.
        do_reset(1'b0);
        repeat (3) step(1'b1, 1000);
        check_all("pre_rst", 1'b1, 1000, 750, 1'b0);
        do_reset(1'b0);
        check_all("mid_rst", 1'b0, 0, 0, 1'b0);
        step(1'b1, 0); check_all("post_1", 1'b1, 0, 0, 1'b0);
        step(1'b1, 0); check_all("post_2", 1'b1, 0, 0, 1'b0);
        step(1'b1, 0); check_all("post_3", 1'b1, 0, 0, 1'b0);
        step(1'b1, 0); check_all("post_4", 1'b1, 0, 0, 1'b1);
        step(1'b1, 0); check_all("post_5", 1'b1, 0, 0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/moving_avg.md
# moving_avg

Boxcar moving-average filter over the ECG sample stream. It produces the `i_ma_short` / `i_ma_long` operands and their valid flags that the absolute-difference stage compares against the raw sample. The design instantiates it twice, short and long window, both fed from the same ECG sample source. Division by the window length is a power-of-two arithmetic shift, so the block is a running sum plus a circular sample buffer.

## Interface
- `DATA_WIDTH`, default 11: signed sample width, two's complement; range -1024..1023.
- `WINDOW_LOG2`, default 5: window length W = 2^WINDOW_LOG2; legal range 1..10.
- `i_clk`, in, 1: single clock; all logic on rising edge.
- `i_rst`, in, 1: synchronous, active-high reset.
- `i_ce`, in, 1: sample strobe; `i_ecg_sample` is accepted on cycles where this is high.
- `i_ecg_sample`, in, DATA_WIDTH, signed: input sample.
- `o_ce`, out, 1: one-cycle pulse, one cycle after each accepted sample.
- `o_ecg_sample`, out, DATA_WIDTH, signed: accepted sample, delayed to align with `o_ma`.
- `o_ma`, out, DATA_WIDTH, signed: moving average of the last W accepted samples.
- `o_ma_valid`, out, 1: level; high once W samples have been accepted since reset.

## Operation
- Internal state:
  - Circular buffer of W samples.
  - Write pointer `wr_ptr` (WINDOW_LOG2 bits; wraps W-1 -> 0).
  - Fill counter `fill_cnt` (WINDOW_LOG2+1 bits; saturates at W).
  - Running sum `sum`, signed, DATA_WIDTH+WINDOW_LOG2 bits.
- Sum width is exact: |sum| <= W*1024, so no overflow or saturation logic is needed.
- Accepted sample x (i_ce=1):
  - `old` = buffer[wr_ptr] if fill_cnt == W, else 0.
  - sum_next = sum + x - old.
  - buffer[wr_ptr] <= x; wr_ptr increments modulo W.
  - fill_cnt increments until it equals W, then holds.
  - sum <= sum_next.
  - o_ma <= sum_next >>> WINDOW_LOG2. This is an arithmetic shift, rounding toward -inf; no rounding correction.
  - o_ecg_sample <= x; o_ce <= 1.
  - o_ma_valid <= 1 when fill_cnt+1 >= W.
- Reading the oldest sample and writing the new one at the same slot in the same cycle is read-before-write: the subtracted value is the pre-write content.
- No sample (i_ce=0): o_ce <= 0; all other state and outputs hold.
- While filling (o_ma_valid=0), o_ma is the partial sum >>> WINDOW_LOG2. This is not a true average; consumers must gate on valid.
- Buffer contents are not reset. Stale data is masked by fill_cnt, so the buffer may map to distributed RAM.

## Timing
- Reset (i_rst=1 at an edge): sum, wr_ptr, fill_cnt, o_ma, o_ecg_sample, o_ce and o_ma_valid all become 0. Reset wins over a simultaneous i_ce.
- Latency: sample accepted at edge n appears with its updated average at edge n+1. o_ce, o_ecg_sample and o_ma change at the same edge.
- o_ma_valid rises at the same edge as the o_ce for the W-th accepted sample. It stays high until the next reset.
- Back-to-back i_ce (every cycle) is supported at full rate. Arbitrary gaps between strobes are also supported.
- Reset mid-fill or mid-stream: the window restarts empty. No sample accepted before reset affects any later o_ma.

## Structure
- Shared package `rpd_pkg` holds:
  - `DATA_WIDTH` default constant.
  - `sample_t` typedef: signed [DATA_WIDTH-1:0].
  - A `sum_width(window_log2)` function.
- Sub-module `sample_ring` holds the circular buffer:
  - Write port: en, addr, data.
  - Asynchronous read port.
  - No reset.
  - Parameters DEPTH_LOG2 and DATA_WIDTH.
- `moving_avg` owns the pointer, fill counter, sum and output registers.

## Test plan
All scenarios use WINDOW_LOG2=2 (W=4).
- Constant 100 on every cycle with i_ce=1 -> o_ma_valid rises with the 4th o_ce; o_ma=100 from then on; o_ecg_sample equals the input delayed by 1 cycle.
- Sequence 4, 8, 12, 16, 20 -> after the 4th sample o_ma=10; after the 5th o_ma=14 (the 4 is subtracted on wrap).
- Sequence -1, 0, 0, 0 -> o_ma=-1 (floor of -0.25). Then 0, 0, 0, 0 -> o_ma=0.
- Extremes: four samples of -1024 -> o_ma=-1024; four samples of 1023 -> o_ma=1023; alternating -1024 and 1023 -> o_ma=-1.
- i_ce pattern 1,0,0,1,0,1,1 with samples 8 each -> outputs hold during gaps; o_ce pulses exactly 4 times; valid after the 4th pulse; o_ma=8.
- Feed 1000 three times, assert i_rst for 1 cycle, then feed 0 four times -> o_ma_valid stays 0 until the 4th post-reset sample, then o_ma=0 (no leakage of 1000).
